// File: rtl/arith_share_pkg.sv
//------------------------------------------------------------------------------
// Module  : arith_share_pkg
// Brief   : Shared types and constants for the arith_share_arb slice.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package arith_share_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   localparam int STAT_W = 32;

endpackage

`default_nettype wire

// File: rtl/arith_share_rr_picker.sv
//------------------------------------------------------------------------------
// Module  : arith_share_rr_picker
// Brief   : Combinational round-robin pick: first valid index at or after rr_ptr.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arith_share_rr_picker
   import arith_share_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any,
   output logic [ID_W-1:0]    win_idx
);

   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   logic [ID_W:0] w_idx [NUM_REQ];

   // Candidate index for each offset from the pointer, wrapped into range.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx[k] = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (w_idx[k] >= NUM_REQ_W) begin
            w_idx[k] = w_idx[k] - NUM_REQ_W;
         end
      end
   end

   // Walk offsets from farthest to nearest so the nearest valid one wins.
   always_comb begin
      any     = 1'b0;
      win_idx = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (req_valid[w_idx[k][ID_W-1:0]]) begin
            any     = 1'b1;
            win_idx = w_idx[k][ID_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/arith_share_arb.sv
//------------------------------------------------------------------------------
// Module  : arith_share_arb
// Brief   : Round-robin sharing of one binary arith unit among NUM_REQ requesters,
//           one transaction in flight. Optional grant counters: ARITH_SHARE_ARB_STATS_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arith_share_arb
   import arith_share_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_data,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_data,
   output logic                     op_a_valid,
   input  logic                     op_a_ready,
   output logic [WIDTH-1:0]         op_a_data,
   output logic                     op_b_valid,
   input  logic                     op_b_ready,
   output logic [WIDTH-1:0]         op_b_data,
   input  logic                     op_result_valid,
   output logic                     op_result_ready,
   input  logic [WIDTH-1:0]         op_result_data,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
`ifdef ARITH_SHARE_ARB_STATS_EN
   output logic [NUM_REQ*STAT_W-1:0] stat_grants,
`endif
   output logic [WIDTH-1:0]         resp_data
);

   arb_state_e          r_state;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_win;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_res;
   logic                r_op_a_valid;
   logic                r_op_b_valid;
   logic                r_res_ready;
   logic [NUM_REQ-1:0]  r_resp_valid;

   logic                w_any;
   logic [ID_W-1:0]     w_win;
   logic                w_accept;

   arith_share_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (r_rr_ptr),
      .any       (w_any),
      .win_idx   (w_win)
   );

   assign w_accept = (r_state == IDLE) && w_any;

   // The grant is the only combinational output: a requester sees ready in
   // the same cycle it is selected.
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_win] = 1'b1;
      end
   end

   assign op_a_valid      = r_op_a_valid;
   assign op_b_valid      = r_op_b_valid;
   assign op_a_data       = r_a;
   assign op_b_data       = r_b;
   assign op_result_ready = r_res_ready;
   assign resp_valid      = r_resp_valid;
   assign resp_data       = r_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_win        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_op_a_valid <= 1'b0;
         r_op_b_valid <= 1'b0;
         r_res_ready  <= 1'b0;
         r_resp_valid <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_win        <= w_win;
                  r_a          <= req_a_data[w_win*WIDTH +: WIDTH];
                  r_b          <= req_b_data[w_win*WIDTH +: WIDTH];
                  r_op_a_valid <= 1'b1;
                  r_op_b_valid <= 1'b1;
                  r_res_ready  <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_op_a_valid && op_a_ready) begin
                  r_op_a_valid <= 1'b0;
               end
               if (r_op_b_valid && op_b_ready) begin
                  r_op_b_valid <= 1'b0;
               end
               // An early result still ends the transaction; pending operands are abandoned.
               if (op_result_valid) begin
                  r_res               <= op_result_data;
                  r_op_a_valid        <= 1'b0;
                  r_op_b_valid        <= 1'b0;
                  r_res_ready         <= 1'b0;
                  r_resp_valid        <= '0;
                  r_resp_valid[r_win] <= 1'b1;
                  r_state             <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[r_win]) begin
                  r_resp_valid <= '0;
                  r_rr_ptr     <= (r_win == ID_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARITH_SHARE_ARB_STATS_EN
   logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      always_ff @(posedge clk) begin
         if (rst) begin
            r_grant_cnt[gi] <= '0;
         end else if (req_ready[gi] && (r_grant_cnt[gi] != {STAT_W{1'b1}})) begin
            r_grant_cnt[gi] <= r_grant_cnt[gi] + 1'b1;
         end
      end
      assign stat_grants[gi*STAT_W +: STAT_W] = r_grant_cnt[gi];
   end : g_stats
`endif

endmodule

`default_nettype wire

// File: tb/tb_arith_share_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_arith_share_arb
// Brief   : Self-checking bench for arith_share_arb with an XOR unit model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arith_share_arb;

   localparam int W = 32;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   a_in [N];
   logic [W-1:0]   b_in [N];
   logic [N*W-1:0] req_a_data;
   logic [N*W-1:0] req_b_data;
   logic           op_a_valid, op_a_ready;
   logic [W-1:0]   op_a_data;
   logic           op_b_valid, op_b_ready;
   logic [W-1:0]   op_b_data;
   logic           op_result_valid, op_result_ready;
   logic [W-1:0]   op_result_data;
   logic [N-1:0]   resp_valid;
   logic [N-1:0]   resp_ready;
   logic [W-1:0]   resp_data;
`ifdef ARITH_SHARE_ARB_STATS_EN
   logic [N*32-1:0] stat_grants;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign req_a_data = {a_in[3], a_in[2], a_in[1], a_in[0]};
   assign req_b_data = {b_in[3], b_in[2], b_in[1], b_in[0]};

   arith_share_arb #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_a_data      (req_a_data),
      .req_b_data      (req_b_data),
      .op_a_valid      (op_a_valid),
      .op_a_ready      (op_a_ready),
      .op_a_data       (op_a_data),
      .op_b_valid      (op_b_valid),
      .op_b_ready      (op_b_ready),
      .op_b_data       (op_b_data),
      .op_result_valid (op_result_valid),
      .op_result_ready (op_result_ready),
      .op_result_data  (op_result_data),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
`ifdef ARITH_SHARE_ARB_STATS_EN
      .stat_grants     (stat_grants),
`endif
      .resp_data       (resp_data)
   );

   // Combinational XOR unit: each operand is taken once; the result is valid
   // as soon as both operands are held or firing.
   logic         ua_got, ub_got;
   logic [W-1:0] ua, ub;
   wire          a_fire = op_a_valid && op_a_ready;
   wire          b_fire = op_b_valid && op_b_ready;
   wire [W-1:0]  ea     = ua_got ? ua : op_a_data;
   wire [W-1:0]  eb     = ub_got ? ub : op_b_data;

   assign op_result_valid = (ua_got || a_fire) && (ub_got || b_fire);
   assign op_result_data  = ea ^ eb;

   always @(posedge clk) begin
      if (rst || (op_result_valid && op_result_ready)) begin
         ua_got <= 1'b0;
         ub_got <= 1'b0;
      end else begin
         if (a_fire) begin ua_got <= 1'b1; ua <= op_a_data; end
         if (b_fire) begin ub_got <= 1'b1; ub <= op_b_data; end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] onehot(input int i);
      return 32'd1 << i;
   endfunction

   // Reference arbitration rule: first valid requester at or after the pointer.
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int           mptr, mwin, wait_cnt, w;
   bit           busy;
   logic [W-1:0] mres;
   logic [N-1:0] granted_prev, exp_ready;

   initial begin
      rst = 1'b1; req_valid = '0; resp_ready = '0;
      op_a_ready = 1'b1; op_b_ready = 1'b1;
      for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("reset_req_ready",  32'(req_ready), 0);
      check("reset_resp_valid", 32'(resp_valid), 0);
      check("reset_op_a_valid", 32'(op_a_valid), 0);
      check("reset_op_b_valid", 32'(op_b_valid), 0);
      check("reset_res_ready",  32'(op_result_ready), 0);
      check("reset_resp_data",  resp_data, 0);

      // All requesters continuously valid: grants rotate every three cycles.
      for (int i = 0; i < N; i++) begin
         a_in[i] = 32'h1111_1111 * (i + 1);
         b_in[i] = 32'h0F0F_0F0F << i;
      end
      req_valid = 4'hF; resp_ready = 4'hF;
      for (int k = 0; k < 15; k++) begin
         #1;
         check("rr_grant", 32'(req_ready), (k % 3 == 0) ? onehot((k / 3) % N) : 32'd0);
         if (k % 3 == 2) begin
            check("rr_resp_valid", 32'(resp_valid), onehot((k / 3) % N));
            check("rr_resp_data", resp_data, a_in[(k / 3) % N] ^ b_in[(k / 3) % N]);
         end
         tick();
      end
`ifdef ARITH_SHARE_ARB_STATS_EN
      check("stat_req0", stat_grants[31:0], 2);
      check("stat_req1", stat_grants[63:32], 1);
      check("stat_req3", stat_grants[127:96], 1);
`endif

      // Single request from requester 1 (pointer now 1).
      req_valid = 4'b0010; a_in[1] = 32'h0F0F_0000; b_in[1] = 32'h00FF_00FF;
      #1;
      check("single_ready_T", 32'(req_ready), 32'b0010);
      check("single_resp_T", 32'(resp_valid), 0);
      tick(); req_valid = '0; #1;
      check("single_resp_T1", 32'(resp_valid), 0);
      check("single_res_ready_T1", 32'(op_result_ready), 1);
      tick(); #1;
      check("single_resp_T2", 32'(resp_valid), 32'b0010);
      check("single_data_T2", resp_data, 32'h0FF0_00FF);
      tick();

      // Operand B stalled for five ISSUE cycles.
      req_valid = 4'b0001; a_in[0] = 32'hDEAD_0000; b_in[0] = 32'h0000_BEEF; op_b_ready = 1'b0;
      #1;
      check("stall_grant", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0; #1;
      check("stall_a_valid_first", 32'(op_a_valid), 1);
      check("stall_b_valid_first", 32'(op_b_valid), 1);
      for (int s = 0; s < 4; s++) begin
         tick(); #1;
         check("stall_a_dropped", 32'(op_a_valid), 0);
         check("stall_b_held", 32'(op_b_valid), 1);
         check("stall_no_resp", 32'(resp_valid), 0);
      end
      tick(); op_b_ready = 1'b1; #1;
      check("stall_b_fire", 32'(op_b_valid), 1);
      check("stall_no_resp_yet", 32'(resp_valid), 0);
      tick(); #1;
      check("stall_resp_valid", 32'(resp_valid), 32'b0001);
      check("stall_resp_data", resp_data, 32'hDEAD_BEEF);
      tick();

      // Requester 2 holds off its response; other resp_ready bits are ignored.
      req_valid = 4'b0100; a_in[2] = 32'h1234_5678; b_in[2] = 32'hFFFF_0000; resp_ready = 4'b1011;
      #1;
      check("hold_grant", 32'(req_ready), 32'b0100);
      tick();
      req_valid = 4'b1001;
      a_in[0] = 32'h0000_0001; b_in[0] = 32'h0000_0003;
      a_in[3] = 32'hA5A5_A5A5; b_in[3] = 32'h5A5A_0000;
      #1;
      check("hold_no_grant_issue", 32'(req_ready), 0);
      for (int s = 0; s < 4; s++) begin
         tick(); #1;
         check("hold_resp_valid", 32'(resp_valid), 32'b0100);
         check("hold_resp_data", resp_data, 32'hEDCB_5678);
         check("hold_no_grant", 32'(req_ready), 0);
      end
      tick(); resp_ready = 4'b0100; #1;
      check("hold_resp_accept", 32'(resp_valid), 32'b0100);
      tick(); resp_ready = 4'hF; #1;
      check("hold_next_is_3", 32'(req_ready), 32'b1000);
      tick(); req_valid = '0; #1;
      tick(); #1;
      check("hold_resp3_valid", 32'(resp_valid), 32'b1000);
      check("hold_resp3_data", resp_data, 32'hFFFF_A5A5);
      tick();

      // Reset while a transaction sits in ISSUE.
      req_valid = 4'b0010; a_in[1] = 32'h0000_00AA; b_in[1] = 32'h0000_0055; op_b_ready = 1'b0;
      #1;
      check("rst_mid_grant", 32'(req_ready), 32'b0010);
      tick(); req_valid = '0; #1;
      check("rst_mid_issue", 32'(op_b_valid), 1);
      rst = 1'b1;
      tick(); rst = 1'b0; op_b_ready = 1'b1; #1;
      check("rst_mid_a_valid", 32'(op_a_valid), 0);
      check("rst_mid_b_valid", 32'(op_b_valid), 0);
      check("rst_mid_res_ready", 32'(op_result_ready), 0);
      check("rst_mid_resp", 32'(resp_valid), 0);
      for (int s = 0; s < 4; s++) begin
         tick(); #1;
         check("rst_mid_no_resp", 32'(resp_valid), 0);
      end
      tick(); req_valid = 4'hF; #1;
      check("rst_mid_ptr0", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      repeat (3) tick();

      // Randomized traffic against the transaction-level model.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      mptr = 0; busy = 1'b0; granted_prev = '0; wait_cnt = 0; mwin = 0; mres = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
               if (granted_prev[i] || $urandom_range(15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               a_in[i] = $urandom; b_in[i] = $urandom; req_valid[i] = 1'b1;
            end
         end
         resp_ready = 4'($urandom);
         op_a_ready = ($urandom_range(3) != 0);
         op_b_ready = ($urandom_range(3) != 0);
         #1;
         granted_prev = '0;
         w = pick(req_valid, mptr);
         if (!busy) begin
            exp_ready = (w >= 0) ? 4'(onehot(w)) : 4'b0;
            check("rnd_grant", 32'(req_ready), 32'(exp_ready));
            check("rnd_idle_resp", 32'(resp_valid), 0);
            if (w >= 0) begin
               busy = 1'b1; mwin = w; mres = a_in[w] ^ b_in[w]; wait_cnt = 0;
               granted_prev = exp_ready;
            end
         end else begin
            check("rnd_busy_no_grant", 32'(req_ready), 0);
            wait_cnt++;
            if (resp_valid != '0) begin
               check("rnd_resp_valid", 32'(resp_valid), onehot(mwin));
               check("rnd_resp_data", resp_data, mres);
               if (resp_ready[mwin]) begin
                  busy = 1'b0;
                  mptr = (mwin + 1) % N;
               end
            end else begin
               check("rnd_timeout", 32'(wait_cnt > 200), 0);
               if (wait_cnt > 200) busy = 1'b0;
            end
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
